// File: rtl/ready_skid_register_if.sv
// Valid/ready/data handshake bundle.
// Master drives valid/data, slave drives ready.
interface ready_skid_register_if #(
  parameter type T = logic
);
  logic valid;
  logic ready;
  T     data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/ready_skid_register.sv
// Fully registered valid/ready pipeline stage.
// Main register feeds the output, skid absorbs one beat of backpressure.
module ready_skid_register #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : g_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;

    logic unused;
    assign unused = clk_i ^ rst_ni ^ flush_i;
  end else begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
    } state_e;

    state_e state_q, state_d;
    T       main_q, main_d;
    T       skid_q, skid_d;
    logic   in_fire;
    logic   out_fire;

    assign valid_o  = (state_q != EMPTY);
    assign ready_o  = (state_q != FULL);
    assign data_o   = main_q;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    // Next state and register loads; flush drops everything
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = data_i;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = data_i;
          end else if (in_fire) begin
            skid_d  = data_i;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (flush_i) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
    end

    // State and storage registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end
  end

endmodule

// File: tb/tb_ready_skid_register.sv
// Bench for ready_skid_register.
// Scoreboard follows every accepted beat to the output.
module tb_ready_skid_register;

  typedef logic [7:0] byte_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  byte_t sb[$];
  byte_t mon_exp;

  ready_skid_register_if #(.T(byte_t)) up ();
  ready_skid_register_if #(.T(byte_t)) dn ();
  ready_skid_register_if #(.T(byte_t)) bup ();
  ready_skid_register_if #(.T(byte_t)) bdn ();

  ready_skid_register #(
    .T     (byte_t),
    .Bypass(1'b0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .valid_i(up.valid),
    .ready_o(up.ready),
    .data_i (up.data),
    .valid_o(dn.valid),
    .ready_i(dn.ready),
    .data_o (dn.data)
  );

  ready_skid_register #(
    .T     (byte_t),
    .Bypass(1'b1)
  ) dut_byp (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .valid_i(bup.valid),
    .ready_o(bup.ready),
    .data_i (bup.data),
    .valid_o(bdn.valid),
    .ready_i(bdn.ready),
    .data_o (bdn.data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push accepted beats, pop and compare emitted beats
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (dn.valid && dn.ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_pop unexpected beat got=%h want=none",
                   dn.data);
        end else begin
          mon_exp = sb.pop_front();
          if (dn.data !== mon_exp) begin
            failures++;
            $display("FAIL sb_pop got=%h want=%h", dn.data, mon_exp);
          end
        end
      end
      if (flush) sb.delete();
      else if (up.valid && up.ready) sb.push_back(up.data);
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (dn.valid !== 1'b0 || up.ready !== 1'b1 || dn.data !== 8'h00) begin
      failures++;
      $display("FAIL reset got v=%b r=%b d=%h want v=0 r=1 d=00",
               dn.valid, up.ready, dn.data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    dn.ready = 1'b1;
    up.valid = 1'b1;
    up.data  = 8'hA5;
    @(negedge clk);
    checks++;
    if (dn.valid !== 1'b1 || dn.data !== 8'hA5) begin
      failures++;
      $display("FAIL single_out got v=%b d=%h want v=1 d=a5",
               dn.valid, dn.data);
    end
    up.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dn.valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain got v=%b want v=0", dn.valid);
    end
  endtask

  task automatic test_stream();
    dn.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        checks++;
        if (dn.valid !== 1'b1 || dn.data !== byte_t'(i - 1)) begin
          failures++;
          $display("FAIL stream_out got v=%b d=%h want v=1 d=%h",
                   dn.valid, dn.data, byte_t'(i - 1));
        end
      end
      checks++;
      if (up.ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready got=%b want=1", up.ready);
      end
      up.valid = 1'b1;
      up.data  = byte_t'(i);
      @(negedge clk);
    end
    up.valid = 1'b0;
    checks++;
    if (dn.valid !== 1'b1 || dn.data !== 8'h07) begin
      failures++;
      $display("FAIL stream_last got v=%b d=%h want v=1 d=07",
               dn.valid, dn.data);
    end
    @(negedge clk);
    checks++;
    if (dn.valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_drain got v=%b want v=0", dn.valid);
    end
  endtask

  task automatic test_backpressure();
    dn.ready = 1'b0;
    up.valid = 1'b1;
    up.data  = 8'h11;
    @(negedge clk);
    checks++;
    if (up.ready !== 1'b1 || dn.data !== 8'h11) begin
      failures++;
      $display("FAIL bp_busy got r=%b d=%h want r=1 d=11",
               up.ready, dn.data);
    end
    up.data = 8'h22;
    @(negedge clk);
    checks++;
    if (up.ready !== 1'b0 || dn.valid !== 1'b1 || dn.data !== 8'h11) begin
      failures++;
      $display("FAIL bp_full got r=%b v=%b d=%h want r=0 v=1 d=11",
               up.ready, dn.valid, dn.data);
    end
    up.valid = 1'b0;
    up.data  = 8'hEE;
    dn.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (up.ready !== 1'b1 || dn.valid !== 1'b1 || dn.data !== 8'h22) begin
      failures++;
      $display("FAIL bp_second got r=%b v=%b d=%h want r=1 v=1 d=22",
               up.ready, dn.valid, dn.data);
    end
    @(negedge clk);
    checks++;
    if (dn.valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got v=%b want v=0", dn.valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    dn.ready = 1'b0;
    up.valid = 1'b1;
    up.data  = 8'h33;
    @(negedge clk);
    up.data = 8'h44;
    @(negedge clk);
    checks++;
    if (up.ready !== 1'b0 || dn.data !== 8'h33) begin
      failures++;
      $display("FAIL flush_full got r=%b d=%h want r=0 d=33",
               up.ready, dn.data);
    end
    flush    = 1'b1;
    up.data  = 8'h55;
    @(negedge clk);
    flush    = 1'b0;
    up.valid = 1'b0;
    checks++;
    if (dn.valid !== 1'b0 || up.ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty got v=%b r=%b want v=0 r=1",
               dn.valid, up.ready);
    end
    dn.ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dn.valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL flush_leak got beats=%0d want=0", seen);
    end
  endtask

  task automatic test_async_reset();
    dn.ready = 1'b0;
    up.valid = 1'b1;
    up.data  = 8'h66;
    @(negedge clk);
    up.valid = 1'b0;
    checks++;
    if (dn.valid !== 1'b1 || dn.data !== 8'h66) begin
      failures++;
      $display("FAIL arst_busy got v=%b d=%h want v=1 d=66",
               dn.valid, dn.data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dn.valid !== 1'b0 || dn.data !== 8'h00 || up.ready !== 1'b1) begin
      failures++;
      $display("FAIL arst got v=%b d=%h r=%b want v=0 d=00 r=1",
               dn.valid, dn.data, up.ready);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    dn.ready = 1'b1;
    up.valid = 1'b1;
    up.data  = 8'h77;
    @(negedge clk);
    up.valid = 1'b0;
    checks++;
    if (dn.valid !== 1'b1 || dn.data !== 8'h77) begin
      failures++;
      $display("FAIL arst_release got v=%b d=%h want v=1 d=77",
               dn.valid, dn.data);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    byte_t d;
    logic  v;
    logic  r;
    for (int i = 0; i < 16; i++) begin
      d = byte_t'($urandom_range(0, 255));
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      bup.valid = v;
      bup.data  = d;
      bdn.ready = r;
      #1;
      checks++;
      if (bdn.valid !== v || bup.ready !== r || bdn.data !== d) begin
        failures++;
        $display("FAIL bypass got v=%b r=%b d=%h want v=%b r=%b d=%h",
                 bdn.valid, bup.ready, bdn.data, v, r, d);
      end
      #2;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    up.valid  = 1'b0;
    up.data   = 8'h00;
    dn.ready  = 1'b0;
    bup.valid = 1'b0;
    bup.data  = 8'h00;
    bdn.ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_bypass();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_drain got left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ready_skid_register.md
READY_SKID_REGISTER -- requirements
Module: ready_skid_register

Interface
REQ-001 SHALL have parameter T, default logic: payload type carried from input to output.
REQ-002 SHALL have parameter Bypass, default 1'b0: when 1, the block is pure wiring.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1: synchronous clear of all buffered beats.
REQ-006 SHALL have port valid_i, input, 1: upstream beat valid.
REQ-007 SHALL have port ready_o, output, 1: block can accept a beat; driven only from a register.
REQ-008 SHALL have port data_i, input, T: upstream payload.
REQ-009 SHALL have port valid_o, output, 1: downstream beat valid; driven only from a register.
REQ-010 SHALL have port ready_i, input, 1: downstream accepts beat.
REQ-011 SHALL have port data_o, output, T: downstream payload; driven only from a register.

Function
REQ-012 SHALL define input fire = valid_i & ready_o and output fire = valid_o & ready_i.
REQ-013 SHALL hold two storage registers: main (drives data_o) and skid (overflow holding).
REQ-014 SHALL implement state machine EMPTY (0 beats), BUSY (1 beat in main), FULL (main and skid both occupied).
REQ-015 SHALL drive valid_o = (state != EMPTY), ready_o = (state != FULL), data_o = main.
REQ-016 SHALL, from EMPTY, on input fire: main <= data_i and go to BUSY; otherwise stay EMPTY.
REQ-017 SHALL, from BUSY, on input fire with output fire: main <= data_i and stay BUSY.
REQ-018 SHALL, from BUSY, on input fire without output fire: skid <= data_i and go to FULL.
REQ-019 SHALL, from BUSY, on output fire without input fire: go to EMPTY.
REQ-020 SHALL, from FULL, on output fire: main <= skid and go to BUSY; input fire cannot occur in FULL.
REQ-021 SHALL have latency of exactly 1 cycle from input fire to valid_o on an EMPTY block, and sustain 1 beat/cycle while ready_i stays high.
REQ-022 SHALL have no combinational path from ready_i to ready_o, nor from valid_i/data_i to valid_o/data_o.
REQ-023 SHALL keep valid_o asserted with data_o stable until output fire; no beat is ever dropped, duplicated or reordered.
REQ-024 SHALL, when flush_i=1 at a clock edge, go to EMPTY regardless of state or simultaneous fires; a beat accepted in that cycle is discarded.
REQ-025 SHALL, when Bypass=1, implement valid_o=valid_i, ready_o=ready_i, data_o=data_i with no storage; flush_i is ignored.
REQ-026 SHALL not update main or skid except as listed in REQ-016..020.

Reset
REQ-027 SHALL, while rst_ni=0, force state EMPTY, main and skid to '0; hence valid_o=0, data_o='0, ready_o=1.
REQ-028 SHALL, when reset is asserted mid-operation (BUSY or FULL), discard all buffered beats immediately and asynchronously.
REQ-029 SHALL leave the first clock edge after reset release free to accept a beat.

Verification
REQ-030 SHALL test single beat (T=logic[7:0]): valid_i=1, data_i=8'hA5 for one cycle with ready_i=1 -> valid_o=1, data_o=8'hA5 exactly one cycle later, then valid_o=0.
REQ-031 SHALL test streaming: 8 beats 8'h00..8'h07 back-to-back with ready_i=1 -> outputs 00..07 on consecutive cycles, ready_o constantly 1.
REQ-032 SHALL test backpressure: ready_i=0, send 8'h11 then 8'h22 -> ready_o falls to 0 after second accept, data_o holds 8'h11; raise ready_i -> 11 then 22 emitted in order, ready_o returns to 1 one cycle after first output fire.
REQ-033 SHALL test flush: in FULL state with 8'h33/8'h44 buffered, pulse flush_i while valid_i=1, data_i=8'h55 -> next cycle valid_o=0, ready_o=1, none of 33/44/55 ever emitted.
REQ-034 SHALL test asynchronous reset: drop rst_ni between edges while BUSY -> valid_o=0, data_o=8'h00, ready_o=1 without waiting for a clock edge.
REQ-035 SHALL test Bypass=1: random valid_i/ready_i/data_i -> outputs equal inputs in the same cycle, zero latency.
